// File: rtl/regbank_mp_if.sv
// Bus bundle between the register bank and its decode/writeback/fetch/issue clients.
// The slave modport is the register bank; the master modport is the client side.
interface regbank_mp_if #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int RD_PORTS = 2
) ();
   logic [RD_PORTS-1:0]        rdReq;
   logic [RD_PORTS*ADDR_W-1:0] rdAddr;
   logic [RD_PORTS-1:0]        rdReady;
   logic [RD_PORTS*DATA_W-1:0] rdData;
   logic                       lockReq;
   logic [ADDR_W-1:0]          lockAddr;
   logic                       wrReq;
   logic [ADDR_W-1:0]          wrAddr;
   logic [DATA_W-1:0]          wrData;
   logic                       wrAck;
   logic                       pcWrEn;
   logic [DATA_W-1:0]          pcIn;
   logic [DATA_W-1:0]          pcOut;
   logic                       cpsrWrEn;
   logic [DATA_W-1:0]          cpsrIn;
   logic [DATA_W-1:0]          cpsrOut;

   modport slave (
      input  rdReq, rdAddr, lockReq, lockAddr, wrReq, wrAddr, wrData,
             pcWrEn, pcIn, cpsrWrEn, cpsrIn,
      output rdReady, rdData, wrAck, pcOut, cpsrOut
   );

   modport master (
      output rdReq, rdAddr, lockReq, lockAddr, wrReq, wrAddr, wrData,
             pcWrEn, pcIn, cpsrWrEn, cpsrIn,
      input  rdReady, rdData, wrAck, pcOut, cpsrOut
   );
endinterface

// File: rtl/regbank_mp.sv
// Multi-read-port register file with PC alias, CPSR and a per-register pending-write
// scoreboard; each read port stalls on a locked register until its writeback lands.
module regbank_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int RD_PORTS = 2,
   parameter int PC_IDX   = 15
) (
   input  logic          clk,
   input  logic          resetn,
   regbank_mp_if.slave   bus
);
   localparam int                DEPTH   = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_VALID} rd_state_t;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0]  r_lock;
   logic [DATA_W-1:0] r_cpsr;
   logic              r_wr_ack;

   rd_state_t         r_state         [RD_PORTS];
   rd_state_t         w_state_nxt     [RD_PORTS];
   logic [ADDR_W-1:0] r_wait_addr     [RD_PORTS];
   logic [ADDR_W-1:0] w_wait_addr_nxt [RD_PORTS];
   logic [DATA_W-1:0] r_rd_data       [RD_PORTS];
   logic [DATA_W-1:0] w_rd_data_nxt   [RD_PORTS];
   logic [ADDR_W-1:0] w_rd_addr       [RD_PORTS];

   // Writeback beats fetch on the PC slot, fetch beats the stored value.
   function automatic logic [DATA_W-1:0] f_capture(
      input logic [ADDR_W-1:0] a,
      input logic [DATA_W-1:0] mem_val,
      input logic              wr_req,
      input logic [ADDR_W-1:0] wr_addr,
      input logic [DATA_W-1:0] wr_data,
      input logic              pc_wr_en,
      input logic [DATA_W-1:0] pc_in
   );
      if (wr_req && (wr_addr == a))
         return wr_data;
      if (pc_wr_en && (a == PC_ADDR))
         return pc_in;
      return mem_val;
   endfunction

   // Storage, scoreboard and status registers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++)
            r_mem[i] <= '0;
         r_lock   <= '0;
         r_cpsr   <= '0;
         r_wr_ack <= 1'b0;
      end else begin
         r_wr_ack <= bus.wrReq;
         if (bus.cpsrWrEn)
            r_cpsr <= bus.cpsrIn;
         if (bus.pcWrEn)
            r_mem[PC_ADDR] <= bus.pcIn;
         if (bus.wrReq) begin
            r_mem[bus.wrAddr]  <= bus.wrData;
            r_lock[bus.wrAddr] <= 1'b0;
         end
         // A new lock request overrides the clear from a same-cycle write.
         if (bus.lockReq)
            r_lock[bus.lockAddr] <= 1'b1;
      end
   end

   always_comb begin
      for (int p = 0; p < RD_PORTS; p++) begin
         w_rd_addr[p]       = bus.rdAddr[p*ADDR_W +: ADDR_W];
         w_state_nxt[p]     = r_state[p];
         w_wait_addr_nxt[p] = r_wait_addr[p];
         w_rd_data_nxt[p]   = r_rd_data[p];
         case (r_state[p])
            S_WAIT: begin
               if (bus.wrReq && (bus.wrAddr == r_wait_addr[p])) begin
                  w_state_nxt[p]   = S_VALID;
                  w_rd_data_nxt[p] = bus.wrData;
               end
            end
            default: begin
               if (!bus.rdReq[p]) begin
                  w_state_nxt[p] = S_IDLE;
               end else if (!r_lock[w_rd_addr[p]] ||
                            (bus.wrReq && (bus.wrAddr == w_rd_addr[p]))) begin
                  w_state_nxt[p]   = S_VALID;
                  w_rd_data_nxt[p] = f_capture(w_rd_addr[p], r_mem[w_rd_addr[p]],
                                               bus.wrReq, bus.wrAddr, bus.wrData,
                                               bus.pcWrEn, bus.pcIn);
               end else begin
                  w_state_nxt[p]     = S_WAIT;
                  w_wait_addr_nxt[p] = w_rd_addr[p];
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      for (int p = 0; p < RD_PORTS; p++) begin
         if (!resetn) begin
            r_state[p]     <= S_IDLE;
            r_wait_addr[p] <= '0;
            r_rd_data[p]   <= '0;
         end else begin
            r_state[p]     <= w_state_nxt[p];
            r_wait_addr[p] <= w_wait_addr_nxt[p];
            r_rd_data[p]   <= w_rd_data_nxt[p];
         end
      end
   end

   always_comb begin
      bus.rdReady = '0;
      bus.rdData  = '0;
      for (int p = 0; p < RD_PORTS; p++) begin
         bus.rdReady[p]                 = (r_state[p] == S_VALID);
         bus.rdData[p*DATA_W +: DATA_W] = r_rd_data[p];
      end
   end

   assign bus.wrAck   = r_wr_ack;
   assign bus.pcOut   = r_mem[PC_ADDR];
   assign bus.cpsrOut = r_cpsr;
endmodule

// File: tb/tb_regbank_mp.sv
// Directed bench for regbank_mp: a per-cycle reference model of the register bank
// plus literal expectations taken from the hand-worked scenarios.
module tb_regbank_mp;
   localparam int DATA_W   = 32;
   localparam int ADDR_W   = 4;
   localparam int RD_PORTS = 2;
   localparam int PC_IDX   = 15;
   localparam int DEPTH    = 16;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   regbank_mp_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_PORTS(RD_PORTS)) bus ();

   regbank_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_PORTS(RD_PORTS), .PC_IDX(PC_IDX)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int n_chk  = 0;
   int n_err  = 0;
   bit chk_en = 1'b0;

   // Reference model: architectural state plus, per port, the register it is waiting on.
   logic [31:0] m_mem  [DEPTH];
   bit          m_lock [DEPTH];
   logic [31:0] m_cpsr;
   bit          m_ack;
   int          m_pend [RD_PORTS];
   bit          m_rdy  [RD_PORTS];
   logic [31:0] m_data [RD_PORTS];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_step();
      int a;
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_lock[i] = 1'b0;
         end
         m_cpsr = '0;
         m_ack  = 1'b0;
         for (int p = 0; p < RD_PORTS; p++) begin
            m_pend[p] = -1;
            m_rdy[p]  = 1'b0;
            m_data[p] = '0;
         end
      end else begin
         for (int p = 0; p < RD_PORTS; p++) begin
            a = int'(bus.rdAddr[p*ADDR_W +: ADDR_W]);
            if (m_pend[p] >= 0) begin
               m_rdy[p] = bus.wrReq && (int'(bus.wrAddr) == m_pend[p]);
               if (m_rdy[p]) begin
                  m_data[p] = bus.wrData;
                  m_pend[p] = -1;
               end
            end else if (!bus.rdReq[p]) begin
               m_rdy[p] = 1'b0;
            end else if (bus.wrReq && (int'(bus.wrAddr) == a)) begin
               m_rdy[p]  = 1'b1;
               m_data[p] = bus.wrData;
            end else if (m_lock[a]) begin
               m_rdy[p]  = 1'b0;
               m_pend[p] = a;
            end else begin
               m_rdy[p]  = 1'b1;
               m_data[p] = (a == PC_IDX && bus.pcWrEn) ? bus.pcIn : m_mem[a];
            end
         end
         if (bus.pcWrEn) m_mem[PC_IDX] = bus.pcIn;
         if (bus.wrReq) begin
            m_mem[bus.wrAddr]  = bus.wrData;
            m_lock[bus.wrAddr] = 1'b0;
         end
         if (bus.lockReq)  m_lock[bus.lockAddr] = 1'b1;
         if (bus.cpsrWrEn) m_cpsr = bus.cpsrIn;
         m_ack = bus.wrReq;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #2;
   endtask

   task automatic clr();
      bus.rdReq    = '0;
      bus.rdAddr   = '0;
      bus.lockReq  = 1'b0;
      bus.lockAddr = '0;
      bus.wrReq    = 1'b0;
      bus.wrAddr   = '0;
      bus.wrData   = '0;
      bus.pcWrEn   = 1'b0;
      bus.pcIn     = '0;
      bus.cpsrWrEn = 1'b0;
      bus.cpsrIn   = '0;
   endtask

   task automatic rd(input int p, input logic [3:0] a);
      bus.rdReq[p]                 = 1'b1;
      bus.rdAddr[p*ADDR_W +: ADDR_W] = a;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      bus.wrReq  = 1'b1;
      bus.wrAddr = a;
      bus.wrData = d;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (chk_en) begin
            for (int p = 0; p < RD_PORTS; p++) begin
               check($sformatf("cyc_rdReady%0d", p), 32'(bus.rdReady[p]), 32'(m_rdy[p]));
               check($sformatf("cyc_rdData%0d", p), bus.rdData[p*DATA_W +: DATA_W], m_data[p]);
            end
            check("cyc_wrAck", 32'(bus.wrAck), 32'(m_ack));
            check("cyc_pcOut", bus.pcOut, m_mem[PC_IDX]);
            check("cyc_cpsrOut", bus.cpsrOut, m_cpsr);
         end
      end
   end

   initial begin
      clr();
      resetn = 1'b0;
      tick(); tick();
      chk_en = 1'b1;
      check("rst_rdReady", 32'(bus.rdReady), 32'd0);
      check("rst_rdData", bus.rdData[31:0], 32'd0);
      check("rst_wrAck", 32'(bus.wrAck), 32'd0);
      check("rst_pcOut", bus.pcOut, 32'd0);
      check("rst_cpsrOut", bus.cpsrOut, 32'd0);
      resetn = 1'b1;

      // Write r3 then read it on port 0.
      wr(4'd3, 32'h0000_00AA); tick();
      check("t1_wrAck", 32'(bus.wrAck), 32'd1);
      clr(); rd(0, 4'd3); tick();
      check("t1_rdReady0", 32'(bus.rdReady[0]), 32'd1);
      check("t1_rdData0", bus.rdData[31:0], 32'h0000_00AA);
      check("t1_wrAck_off", 32'(bus.wrAck), 32'd0);
      clr(); tick();
      check("t1_rdReady0_off", 32'(bus.rdReady[0]), 32'd0);
      check("t1_rdData0_held", bus.rdData[31:0], 32'h0000_00AA);

      // Same-cycle write and read of r5 bypasses the old value.
      wr(4'd5, 32'h0000_5555); tick();
      clr(); wr(4'd5, 32'h0000_1234); rd(1, 4'd5); tick();
      check("t2_rdReady1", 32'(bus.rdReady[1]), 32'd1);
      check("t2_rdData1", bus.rdData[63:32], 32'h0000_1234);

      // Locked r7 stalls port 0; address changes while waiting are ignored.
      clr(); bus.lockReq = 1'b1; bus.lockAddr = 4'd7; tick();
      clr(); tick();
      rd(0, 4'd7); tick();
      rd(0, 4'd3);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t3_stall", 32'(bus.rdReady[0]), 32'd0);
      end
      clr(); wr(4'd7, 32'h0000_0077); tick();
      check("t3_rdReady0", 32'(bus.rdReady[0]), 32'd1);
      check("t3_rdData0", bus.rdData[31:0], 32'h0000_0077);
      clr(); rd(0, 4'd7); tick();
      check("t3_unlocked", 32'(bus.rdReady[0]), 32'd1);

      // Lock and write to r8 in one cycle: the lock survives.
      clr(); bus.lockReq = 1'b1; bus.lockAddr = 4'd8; wr(4'd8, 32'h0000_0088); tick();
      clr(); rd(0, 4'd8); tick();
      check("t3b_setwins", 32'(bus.rdReady[0]), 32'd0);
      clr(); tick();
      wr(4'd8, 32'h0000_0099); tick();
      check("t3b_rdData0", bus.rdData[31:0], 32'h0000_0099);

      // Read on the same edge as the lock is not stalled.
      clr(); bus.lockReq = 1'b1; bus.lockAddr = 4'd4; rd(1, 4'd4); tick();
      check("t3c_rdReady1", 32'(bus.rdReady[1]), 32'd1);
      clr(); wr(4'd4, 32'h0000_0044); tick();

      // PC slot: writeback beats fetch, fetch alone updates, fetch bypass on read.
      clr(); bus.pcWrEn = 1'b1; bus.pcIn = 32'h100; wr(4'd15, 32'h200); tick();
      check("t4_pc_wb", bus.pcOut, 32'h0000_0200);
      clr(); bus.pcWrEn = 1'b1; bus.pcIn = 32'h104; tick();
      check("t4_pc_fetch", bus.pcOut, 32'h0000_0104);
      clr(); bus.pcWrEn = 1'b1; bus.pcIn = 32'h108; rd(0, 4'd15); tick();
      check("t4_pc_bypass", bus.rdData[31:0], 32'h0000_0108);

      // CPSR load, then both ports read r2 together and back-to-back.
      clr(); bus.cpsrWrEn = 1'b1; bus.cpsrIn = 32'h6000_0000; tick();
      check("t5_cpsr", bus.cpsrOut, 32'h6000_0000);
      clr(); wr(4'd2, 32'h3); tick();
      clr(); rd(0, 4'd2); rd(1, 4'd2); tick();
      check("t5_both_ready", 32'(bus.rdReady), 32'd3);
      check("t5_data0", bus.rdData[31:0], 32'h3);
      check("t5_data1", bus.rdData[63:32], 32'h3);
      wr(4'd2, 32'hA5); tick();
      check("t5_stream0", bus.rdData[31:0], 32'hA5);
      check("t5_stream1", bus.rdData[63:32], 32'hA5);

      // Reset while port 0 waits on r9 aborts the read and clears the lock.
      clr(); bus.lockReq = 1'b1; bus.lockAddr = 4'd9; tick();
      clr(); rd(0, 4'd9); tick();
      check("t6_wait", 32'(bus.rdReady[0]), 32'd0);
      clr(); resetn = 1'b0; tick();
      resetn = 1'b1;
      check("t6_rdReady", 32'(bus.rdReady), 32'd0);
      check("t6_rdData", bus.rdData[31:0], 32'd0);
      check("t6_pcOut", bus.pcOut, 32'd0);
      check("t6_cpsrOut", bus.cpsrOut, 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6_no_pulse", 32'(bus.rdReady[0]), 32'd0);
      end
      rd(0, 4'd9); tick();
      check("t6_lock_clear", 32'(bus.rdReady[0]), 32'd1);
      check("t6_r9_zero", bus.rdData[31:0], 32'd0);
      clr(); tick(); tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
